cache_fill_fsm: RTL and testbench

- Miss handler for the next-generation (pipelined, cached) CPU. Replaces the single-cycle instruction/data memory access path with a block-fill engine.
- On a cache miss, it fetches a whole block from a pipelined multi-cycle main memory and streams the words into the cache data array. It then writes the tag and releases the pipeline stall.
- One instance sits in front of the I-cache and one in front of the D-cache. An arbiter above them selects which one may drive memory.

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/cache_fill_fsm_if.sv | 44 ++++
 rtl/cache_fill_fsm_fill_counter.sv | 35 +++
 rtl/cache_fill_fsm.sv | 144 ++++++++++++++
 tb/tb_cache_fill_fsm.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the cache miss-handling path: fill FSM states,
// word geometry and index/counter width helpers.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } fill_state_t;

    localparam int unsigned WORD_BYTES = 2;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra bit so a counter can hold the full block size itself.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return idx_bits(n) + 1;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss, memory-read and cache-write signals of one fill engine.
// crit_word_valid exists only when CACHE_FILL_CRITICAL_WORD_FIRST_EN is defined.
interface cache_fill_fsm_if #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8
);
    localparam int unsigned IDX_W = cpu_mem_pkg::idx_bits(WORDS_PER_BLOCK);

    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  mem_data_valid;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  fsm_busy;
    logic                  write_data_array;
    logic [IDX_W-1:0]      fill_word_idx;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  write_tag_array;
    logic [ADDR_WIDTH-1:0] fill_tag_addr;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic                  crit_word_valid;
`endif

    modport master (
        input  miss_detected, miss_address, mem_data_valid, mem_data_in,
        output mem_en, mem_addr, fsm_busy, write_data_array, fill_word_idx,
               fill_data, write_tag_array, fill_tag_addr
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        , output crit_word_valid
`endif
    );

    modport slave (
        output miss_detected, miss_address, mem_data_valid, mem_data_in,
        input  mem_en, mem_addr, fsm_busy, write_data_array, fill_word_idx,
               fill_data, write_tag_array, fill_tag_addr
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        , input crit_word_valid
`endif
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Clearable up-counter; tc_o flags the increment that reaches limit_i.
module fill_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = inc_i && ((count_q + WIDTH'(1)) == limit_i);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block-fill engine: issues one pipelined read per word, writes returned
// words into the data array, then the tag. Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_fill_fsm_if.master     bus
);
    localparam int unsigned IW       = idx_bits(WORDS_PER_BLOCK);
    localparam int unsigned CW       = cnt_bits(WORDS_PER_BLOCK);
    localparam int unsigned OFF_BITS = CW;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK    = ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [CW-1:0]         BLOCK_WORDS = CW'(WORDS_PER_BLOCK);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("MEM_LATENCY must be 1..15");
    end
    if (WORDS_PER_BLOCK < 2 || WORDS_PER_BLOCK > 64 ||
        (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_block
        $error("WORDS_PER_BLOCK must be a power of two in 2..64");
    end

    fill_state_t           state_q;
    logic                  busy_q, mem_en_q, we_q, tag_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q, tag_addr_q, miss_base;
    logic [IW-1:0]         idx_q, start_q, miss_start;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  accept, issuing, receiving, issue_last, recv_last;
    logic [CW-1:0]         issue_cnt, recv_cnt;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [IW-1:0]         off);
        return base + ADDR_WIDTH'(off) * ADDR_WIDTH'(WORD_BYTES);
    endfunction

    // Block offset in issue/write order: start word plus count, wrapping in the block.
    function automatic logic [IW-1:0] rot(input logic [IW-1:0] start, input logic [CW-1:0] n);
        return IW'(CW'(start) + n);
    endfunction

    assign miss_base = bus.miss_address & ~OFF_MASK;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign miss_start = bus.miss_address[OFF_BITS-1:1];
    logic crit_q;
    assign bus.crit_word_valid = crit_q;
`else
    assign miss_start = '0;
`endif

    assign accept    = (state_q == IDLE) && bus.miss_detected;
    assign issuing   = (state_q == ISSUE);
    assign receiving = ((state_q == ISSUE) || (state_q == WAIT)) && bus.mem_data_valid;

    fill_counter #(.WIDTH(CW)) u_issue_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(accept), .inc_i(issuing),
        .limit_i(BLOCK_WORDS), .count_o(issue_cnt), .tc_o(issue_last)
    );

    fill_counter #(.WIDTH(CW)) u_recv_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(accept), .inc_i(receiving),
        .limit_i(BLOCK_WORDS), .count_o(recv_cnt), .tc_o(recv_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            tag_q      <= 1'b0;
            tag_addr_q <= '0;
            start_q    <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            crit_q     <= 1'b0;
`endif
        end else begin
            we_q  <= 1'b0;
            tag_q <= 1'b0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            crit_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.miss_detected) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= word_addr(miss_base, miss_start);
                        tag_addr_q <= miss_base;
                        start_q    <= miss_start;
                    end
                end
                ISSUE: begin
                    if (issue_last) begin
                        state_q    <= WAIT;
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        mem_addr_q <= word_addr(tag_addr_q, rot(start_q, issue_cnt + CW'(1)));
                    end
                end
                WAIT: ;
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // Responses may overlap issue; the last one lands its write together with the tag.
            if (receiving) begin
                we_q   <= 1'b1;
                data_q <= bus.mem_data_in;
                idx_q  <= rot(start_q, recv_cnt);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                crit_q <= (recv_cnt == '0);
`endif
                if (recv_last) begin
                    state_q <= DONE;
                    tag_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_en           = mem_en_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.fsm_busy         = busy_q;
    assign bus.write_data_array = we_q;
    assign bus.fill_word_idx    = idx_q;
    assign bus.fill_data        = data_q;
    assign bus.write_tag_array  = tag_q;
    assign bus.fill_tag_addr    = tag_addr_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm against a cycle-scheduled reference of
// the fill protocol, with a pipelined memory model of fixed latency.
module tb_cache_fill_fsm;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned IW = $clog2(W);
    localparam int          N  = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_fill_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(W)) bus ();

    cache_fill_fsm #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(W), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic          busy;
        logic          en;
        logic [AW-1:0] addr;
        logic          we;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          tag;
        logic [AW-1:0] taddr;
        logic          crit;
    } obs_t;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } req_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    obs_t          tr [N];
    obs_t          ex [N];
    logic          sched_miss [N];
    logic [AW-1:0] sched_addr [N];
    logic          sched_rst  [N];
    logic [DW-1:0] salt;
    logic [AW-1:0] m_taddr;
    req_t          pend [$];

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a) ^ salt;
    endfunction

    function automatic obs_t sample();
        obs_t o = '0;
        o.busy  = bus.fsm_busy;
        o.en    = bus.mem_en;
        if (bus.mem_en) o.addr = bus.mem_addr;
        o.we    = bus.write_data_array;
        if (bus.write_data_array) begin
            o.idx  = bus.fill_word_idx;
            o.data = bus.fill_data;
        end
        o.tag   = bus.write_tag_array;
        o.taddr = bus.fill_tag_addr;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        o.crit  = bus.crit_word_valid;
`endif
        return o;
    endfunction

    function automatic void clear_sched();
        salt = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            sched_miss[i] = 1'b0;
            sched_addr[i] = AW'($urandom);
            sched_rst[i]  = 1'b1;
        end
    endfunction

    // Reference: accepted at cycle a -> requests a+1.., writes a+L+2.., busy until a+W+L+1.
    function automatic void add_fill(input int a, input int n, input logic [AW-1:0] addr);
        int            s;
        int            c;
        logic [AW-1:0] base;
        base = addr & ~AW'((2 * W) - 1);
        s    = CWF ? int'((addr >> 1) % W) : 0;
        for (c = a + 1; c < n; c++) ex[c].taddr = base;
        for (c = a + 1; c <= a + int'(W + L) + 1 && c < n; c++) ex[c].busy = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            c = a + 1 + i;
            if (c < n) begin
                ex[c].en   = 1'b1;
                ex[c].addr = base + AW'(2 * ((s + i) % W));
            end
            c = a + int'(L) + 2 + i;
            if (c < n) begin
                ex[c].we   = 1'b1;
                ex[c].idx  = IW'((s + i) % W);
                ex[c].data = mem_word(base + AW'(2 * ((s + i) % W)));
                ex[c].crit = CWF && (i == 0);
            end
        end
        c = a + int'(W + L) + 1;
        if (c < n) ex[c].tag = 1'b1;
    endfunction

    function automatic void build_model(input int n);
        int free_from = 0;
        for (int k = 0; k < n; k++) begin
            ex[k]       = '0;
            ex[k].taddr = m_taddr;
        end
        for (int k = 0; k < n; k++) begin
            if (!sched_rst[k]) begin
                for (int j = k + 1; j < n; j++) ex[j] = '0;
                free_from = k + 1;
            end else if (sched_miss[k] && k >= free_from) begin
                add_fill(k, n, sched_addr[k]);
                free_from = k + int'(W + L) + 2;
            end
        end
    endfunction

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr[k] = sample();
            if (bus.mem_en) pend.push_back('{cyc + int'(L), bus.mem_addr});
            if (pend.size() > 0 && pend[0].due == cyc) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.mem_data_valid = 1'b0;
                bus.mem_data_in    = DW'($urandom);
            end
            rst_n             = sched_rst[k];
            bus.miss_detected = sched_miss[k];
            bus.miss_address  = sched_addr[k];
            cyc++;
        end
        m_taddr = ex[n-1].taddr;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.miss_detected  = 1'b1;
        bus.miss_address   = AW'($urandom);
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = DW'($urandom);
        for (int i = 0; i < 3; i++) begin
            obs_t o;
            @(negedge clk);
            o = sample();
            checks++;
            if (o !== obs_t'('0)) begin
                errors++;
                $display("FAIL reset_state cyc %0d got %p exp all zero", i, o);
            end
            bus.mem_data_valid = ~bus.mem_data_valid;
        end
        rst_n              = 1'b1;
        bus.miss_detected  = 1'b0;
        bus.mem_data_valid = 1'b0;
        m_taddr            = '0;
    endtask

    task automatic test_default_fill();
        int fall = -1;
        int wr   = 0;
        clear_sched();
        sched_miss[0] = 1'b1;
        sched_addr[0] = 16'h1236;
        build_model(20);
        run(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (tr[k] !== ex[k]) begin
                errors++;
                $display("FAIL default_fill cyc %0d got %p exp %p", k, tr[k], ex[k]);
            end
            if (tr[k].we) wr++;
            if (k > 1 && fall < 0 && tr[k-1].busy && !tr[k].busy) fall = k;
        end
        checks++;
        if (fall != int'(W + L) + 2) begin
            errors++;
            $display("FAIL fill_latency got %0d exp %0d", fall, W + L + 2);
        end
        checks++;
        if (wr != int'(W)) begin
            errors++;
            $display("FAIL write_count got %0d exp %0d", wr, W);
        end
    endtask

    task automatic test_ignored_miss();
        clear_sched();
        sched_miss[0] = 1'b1;
        sched_addr[0] = AW'($urandom);
        sched_miss[3] = 1'b1;
        sched_miss[9] = 1'b1;
        sched_miss[13] = 1'b1;
        build_model(22);
        run(22);
        for (int k = 0; k < 22; k++) begin
            checks++;
            if (tr[k] !== ex[k]) begin
                errors++;
                $display("FAIL ignored_miss cyc %0d got %p exp %p", k, tr[k], ex[k]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int late = 0;
        int rc   = int'(L) + 4;
        clear_sched();
        sched_miss[0]  = 1'b1;
        sched_addr[0]  = AW'($urandom);
        sched_rst[rc]  = 1'b0;
        build_model(24);
        run(24);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (tr[k] !== ex[k]) begin
                errors++;
                $display("FAIL reset_mid_fill cyc %0d got %p exp %p", k, tr[k], ex[k]);
            end
            if (k > rc && (tr[k].we || tr[k].tag)) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL writes_after_reset got %0d exp 0", late);
        end
    endtask

    task automatic test_back_to_back();
        int t = int'(W + L) + 2;
        clear_sched();
        sched_miss[0] = 1'b1;
        sched_addr[0] = AW'($urandom);
        for (int k = 1; k < t; k++) sched_miss[k] = 1'b1;
        sched_miss[t] = 1'b1;
        sched_addr[t] = 16'hFFF2;
        build_model(2 * t + 6);
        run(2 * t + 6);
        for (int k = 0; k < 2 * t + 6; k++) begin
            checks++;
            if (tr[k] !== ex[k]) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %p exp %p", k, tr[k], ex[k]);
            end
        end
        checks++;
        if (tr[t].busy !== 1'b0 || tr[t+1].busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_gap got busy %b,%b exp 0,1", tr[t].busy, tr[t+1].busy);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_sched();
            for (int k = 0; k <= 40; k++) sched_miss[k] = ($urandom_range(3) == 0);
            build_model(N);
            run(N);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (tr[k] !== ex[k]) begin
                    errors++;
                    $display("FAIL random_%0d cyc %0d got %p exp %p", r, k, tr[k], ex[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_fill();
        test_ignored_miss();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
